// File: rtl/cd_llc_responder.sv
// LLC-side crossbar endpoint: buffers request flits and returns one reply per request
// after RESP_LAT service cycles. Define CD_LLC_RESP_CNT_EN to add rsp_cnt and drop_err.
module cd_llc_responder #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned LLC_ID     = 0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESP_LAT   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_si,
  output logic              req_ri,
  input  logic [DATA_W-1:0] req_di,
  output logic              rsp_so,
  input  logic              rsp_ro,
  output logic [DATA_W-1:0] rsp_do,
`ifdef CD_LLC_RESP_CNT_EN
  output logic [15:0]       rsp_cnt,
  output logic              drop_err,
`endif
  output logic              busy
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = (RESP_LAT > 1) ? $clog2(RESP_LAT + 1) : 1;
  localparam logic [CntW-1:0] LatLoad = CntW'(RESP_LAT);
  localparam logic [1:0]      LlcId   = 2'(LLC_ID);

  typedef enum logic [1:0] {StIdle, StWait, StSend} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic                rsp_so_q;
  logic [DATA_W-1:0]   rsp_q;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic                fifo_empty, fifo_full, push, pop;
  logic [DATA_W-1:0]   req_fmt, fifo_head;
  logic                unused_req;

  // Replies are formatted on entry so the FIFO holds ready-to-send flits.
  assign req_fmt = {req_di[63], 2'b00, 5'b0_0000, req_di[43:40], req_di[35:32],
                    6'b00_0000, LlcId, 8'h00, req_di[31:0]};
  assign unused_req = ^{req_di[62:44], req_di[39:36]};

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

  // Ready is forced low while reset is held so nothing is accepted before release.
  assign req_ri = reset && !fifo_full;
  assign push   = req_si && req_ri;
  assign pop    = !fifo_empty &&
                  ((state_q == StIdle) || ((state_q == StSend) && rsp_ro));

  assign rsp_so = rsp_so_q;
  assign rsp_do = rsp_q;
  assign busy   = (state_q != StIdle) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= req_fmt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rsp_so_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            rsp_q   <= fifo_head;
            cnt_q   <= LatLoad;
            state_q <= StWait;
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            state_q  <= StSend;
            rsp_so_q <= 1'b1;
          end
        end
        StSend: begin
          if (rsp_ro) begin
            rsp_so_q <= 1'b0;
            if (!fifo_empty) begin
              rsp_q   <= fifo_head;
              cnt_q   <= LatLoad;
              state_q <= StWait;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CD_LLC_RESP_CNT_EN
  logic [15:0] rsp_cnt_q;
  logic [7:0]  blk_q;
  logic        drop_err_q;

  assign rsp_cnt  = rsp_cnt_q;
  assign drop_err = drop_err_q;

  // blk_q counts prior consecutive blocked edges; the 256th blocked edge sets the flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_cnt_q  <= '0;
      blk_q      <= '0;
      drop_err_q <= 1'b0;
    end else begin
      if (rsp_so_q && rsp_ro) rsp_cnt_q <= rsp_cnt_q + 16'd1;
      if (req_si && !req_ri) begin
        if (blk_q == 8'hFF) drop_err_q <= 1'b1;
        else                blk_q      <= blk_q + 8'd1;
      end else begin
        blk_q <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cd_llc_responder.sv
// Scoreboard bench for cd_llc_responder (LLC_ID=2): directed latency/order/full/reset
// scenarios plus randomized traffic, checked against a field-level reply model.
module tb_cd_llc_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_si, req_ri, rsp_so, rsp_ro, busy;
  logic [63:0] req_di, rsp_do;
`ifdef CD_LLC_RESP_CNT_EN
  logic [15:0] rsp_cnt;
  logic        drop_err;
`endif

  cd_llc_responder #(
    .DATA_W     (64),
    .LLC_ID     (2),
    .FIFO_DEPTH (4),
    .RESP_LAT   (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_si   (req_si),
    .req_ri   (req_ri),
    .req_di   (req_di),
    .rsp_so   (rsp_so),
    .rsp_ro   (rsp_ro),
    .rsp_do   (rsp_do),
`ifdef CD_LLC_RESP_CNT_EN
    .rsp_cnt  (rsp_cnt),
    .drop_err (drop_err),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;
  logic [63:0] exp_q [$];
  int rise_q [$];
  int so_hi_cnt = 0;
  logic [63:0] last_rsp = '0;
  logic prev_so = 1'b0, prev_hold = 1'b0;
  logic [63:0] prev_do = '0;
  int hs_cnt = 0;
  int blk = 0;
  logic exp_drop = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reply model: pick named request fields and assemble the reply from them.
  function automatic logic [63:0] model(input logic [63:0] r);
    logic       vc;
    logic [7:0] srcx, srcy;
    logic [31:0] payload;
    vc = r[63];
    srcx = r[47:40];
    srcy = r[39:32];
    payload = r[31:0];
    return {vc, 1'b0, 1'b0, 5'd0, srcx[3:0], srcy[3:0], 8'd2, 8'd0, payload};
  endfunction

  always @(posedge clk) edge_cnt++;

  // Monitor: samples at negedge, where inputs and outputs are settled for the next edge.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      prev_so = 1'b0;
      prev_hold = 1'b0;
      hs_cnt = 0;
      blk = 0;
      exp_drop = 1'b0;
    end else begin
`ifdef CD_LLC_RESP_CNT_EN
      chk("rsp_cnt", 64'(rsp_cnt), 64'(hs_cnt[15:0]));
      chk("drop_err", 64'(drop_err), 64'(exp_drop));
      if (req_si && !req_ri) begin
        blk++;
        if (blk >= 256) exp_drop = 1'b1;
      end else begin
        blk = 0;
      end
`endif
      if (rsp_so) so_hi_cnt++;
      if (rsp_so && !prev_so) rise_q.push_back(edge_cnt);
      if (prev_hold) chk("rsp_do_stable", rsp_do, prev_do);
      if (rsp_so && rsp_ro) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_reply: got %h expected none", rsp_do);
        end else begin
          chk("reply", rsp_do, exp_q.pop_front());
        end
        last_rsp = rsp_do;
        hs_cnt++;
      end
      if (req_si && req_ri) exp_q.push_back(model(req_di));
      prev_hold = rsp_so && !rsp_ro;
      prev_do = rsp_do;
      prev_so = rsp_so;
    end
  end

  task automatic cycle(input logic v, input logic [63:0] d, input logic ro,
                       output logic acc, output int e);
    @(posedge clk);
    #1;
    req_si = v;
    req_di = d;
    rsp_ro = ro;
    @(negedge clk);
    acc = req_si && req_ri;
    e = edge_cnt + 1;
  endtask

  task automatic drain();
    logic acc;
    int e;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 300) begin
      cycle(1'b0, 64'd0, 1'b1, acc, e);
      n++;
    end
    chk("drain_done", 64'(exp_q.size() == 0 && !busy), 64'd1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_si = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc, ri_after;
    int e, acc_edge, nacc, n;
    logic [63:0] d;

    reset = 1'b0;
    req_si = 1'b0;
    req_di = '0;
    rsp_ro = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_req_ri", 64'(req_ri), 64'd0);
    chk("rst_rsp_so", 64'(rsp_so), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_do", rsp_do, 64'd0);
    reset = 1'b1;
    #1;
    chk("rel_req_ri", 64'(req_ri), 64'd1);
    chk("rel_rsp_so", 64'(rsp_so), 64'd0);
    chk("rel_busy", 64'(busy), 64'd0);

    // Single request latency and field construction.
    rise_q.delete();
    so_hi_cnt = 0;
    cycle(1'b1, 64'hC033_AA55_0000_0007, 1'b1, acc, acc_edge);
    chk("single_acc", 64'(acc), 64'd1);
    repeat (8) cycle(1'b0, 64'd0, 1'b1, acc, e);
    chk("single_rises", 64'(rise_q.size()), 64'd1);
    if (rise_q.size() > 0) chk("single_lat", 64'(rise_q[0] - acc_edge), 64'd4);
    chk("single_so_cycles", 64'(so_hi_cnt), 64'd1);
    chk("single_flit", last_rsp, 64'h80A5_0200_0000_0007);

    // Back-to-back requests: ordered replies, 4 cycles apart.
    rise_q.delete();
    for (int i = 0; i < 4; i++) begin
      d = {32'h1234_5678, 32'h10 + 32'(i)};
      cycle(1'b1, d, 1'b1, acc, e);
      chk("b2b_acc", 64'(acc), 64'd1);
    end
    repeat (20) cycle(1'b0, 64'd0, 1'b1, acc, e);
    chk("b2b_rises", 64'(rise_q.size()), 64'd4);
    for (int i = 0; i + 1 < rise_q.size(); i++)
      chk("b2b_spacing", 64'(rise_q[i+1] - rise_q[i]), 64'd4);
    chk("b2b_last_tag", 64'(last_rsp[31:0]), 64'h13);

    // Backpressure: 5 of 6 accepted, then ready drops until the first reply pops.
    nacc = 0;
    ri_after = 1'b1;
    for (int i = 0; i < 6; i++) begin
      d = {$urandom, 32'h20 + 32'(nacc)};
      cycle(1'b1, d, 1'b0, acc, e);
      if (acc) nacc++;
      if (i == 5) ri_after = req_ri;
    end
    chk("full_accepts", 64'(nacc), 64'd5);
    chk("full_req_ri", 64'(ri_after), 64'd0);
    chk("full_busy", 64'(busy), 64'd1);
    cycle(1'b0, 64'd0, 1'b1, acc, e);
    chk("full_req_ri_hold", 64'(req_ri), 64'd0);
    cycle(1'b0, 64'd0, 1'b1, acc, e);
    chk("full_req_ri_pop", 64'(req_ri), 64'd1);
    drain();
    chk("full_last_tag", 64'(last_rsp[31:0]), 64'h24);

    // Asynchronous reset while in WAIT with 3 requests queued.
    for (int i = 0; i < 4; i++) begin
      d = {$urandom, 32'h30 + 32'(i)};
      cycle(1'b1, d, 1'b1, acc, e);
    end
    @(posedge clk);
    #2;
    chk("mid_busy_pre", 64'(busy), 64'd1);
    req_si = 1'b0;
    reset = 1'b0;
    #1;
    chk("mid_rsp_so", 64'(rsp_so), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_req_ri", 64'(req_ri), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    so_hi_cnt = 0;
    repeat (15) cycle(1'b0, 64'd0, 1'b1, acc, e);
    chk("mid_no_stale", 64'(so_hi_cnt), 64'd0);
    chk("mid_idle", 64'(busy), 64'd0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 500; i++) begin
      d = {$urandom, $urandom};
      cycle(($urandom % 3) != 0, d, ($urandom % 4) != 0, acc, e);
    end
    drain();

`ifdef CD_LLC_RESP_CNT_EN
    do_reset();
    nacc = 0;
    n = 0;
    while (nacc < 20 && n < 200) begin
      d = {$urandom, $urandom};
      cycle(1'b1, d, 1'b1, acc, e);
      if (acc) nacc++;
      n++;
    end
    req_si = 1'b0;
    drain();
    chk("cnt_20", 64'(rsp_cnt), 64'd20);
    for (int i = 0; i < 300; i++) begin
      d = {$urandom, $urandom};
      cycle(1'b1, d, 1'b0, acc, e);
    end
    chk("drop_set", 64'(drop_err), 64'd1);
    drain();
    chk("drop_sticky", 64'(drop_err), 64'd1);
    do_reset();
    #1;
    chk("drop_clr", 64'(drop_err), 64'd0);
    chk("cnt_clr", 64'(rsp_cnt), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
